// File: rtl/tagged_arith_pipe.sv
// Pipelined signed add/sub/mul/pass unit with an aligned tag sideband,
// ready/valid backpressure, bubble collapsing, flush, and optional saturation.
// Stage 0 holds the computed result; later stages are pure delay.
module tagged_arith_pipe #(
    parameter int DATA_W = 24,
    parameter int TAG_W  = 1,
    parameter int STAGES = 4,
    parameter int SAT    = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_ovf,
    output logic              busy
);

    localparam logic [DATA_W-1:0] MAX_VAL = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};

    // Returns {ovf, result}. Full-precision result is formed first; ovf is set
    // when it does not fit DATA_W signed, and SAT picks clamp versus wrap.
    function automatic logic [DATA_W:0] compute(input logic [1:0]        op,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
        logic [DATA_W:0]     s;
        logic [2*DATA_W-1:0] ax;
        logic [2*DATA_W-1:0] bx;
        logic [2*DATA_W-1:0] p;
        logic [DATA_W-1:0]   r;
        logic                ov;
        logic                neg;
        s   = '0;
        ax  = {{DATA_W{a[DATA_W-1]}}, a};
        bx  = {{DATA_W{b[DATA_W-1]}}, b};
        p   = '0;
        r   = a;
        ov  = 1'b0;
        neg = 1'b0;
        case (op)
            2'b00: begin
                s   = {a[DATA_W-1], a} + {b[DATA_W-1], b};
                r   = s[DATA_W-1:0];
                ov  = s[DATA_W] ^ s[DATA_W-1];
                neg = s[DATA_W];
            end
            2'b01: begin
                s   = {a[DATA_W-1], a} - {b[DATA_W-1], b};
                r   = s[DATA_W-1:0];
                ov  = s[DATA_W] ^ s[DATA_W-1];
                neg = s[DATA_W];
            end
            2'b10: begin
                // Low 2*DATA_W bits of the sign-extended product are exact.
                p   = ax * bx;
                r   = p[DATA_W-1:0];
                ov  = !((&p[2*DATA_W-1:DATA_W-1]) || !(|p[2*DATA_W-1:DATA_W-1]));
                neg = p[2*DATA_W-1];
            end
            default: begin
                r   = a;
                ov  = 1'b0;
                neg = 1'b0;
            end
        endcase
        if ((SAT != 0) && ov) begin
            r = neg ? MIN_VAL : MAX_VAL;
        end else begin
            r = r;
        end
        return {ov, r};
    endfunction

    logic [STAGES-1:0] valid;
    logic [STAGES-1:0] en;
    logic [STAGES-1:0] ovf;
    logic [DATA_W-1:0] data [STAGES];
    logic [TAG_W-1:0]  tag  [STAGES];
    logic [DATA_W:0]   result;
    logic              hole;

    // Arithmetic for the beat currently on the input port.
    always_comb begin
        result = compute(in_op, in_a, in_b);
    end

    // Stage enables: a stage may load if it or any stage downstream is empty,
    // or the consumer is taking the output beat.
    always_comb begin
        en   = '0;
        hole = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            hole  = hole | ~valid[i];
            en[i] = hole;
        end
    end

    assign in_ready  = en[0] & ~flush;
    assign out_valid = valid[STAGES-1];
    assign out_data  = data[STAGES-1];
    assign out_tag   = tag[STAGES-1];
    assign out_ovf   = ovf[STAGES-1];
    assign busy      = |valid;

    // Valid bits: flush drops everything, otherwise each enabled stage takes
    // its upstream valid so bubbles collapse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid <= '0;
        end else if (flush) begin
            valid <= '0;
        end else begin
            if (en[0]) begin
                valid[0] <= in_valid;
            end
            for (int i = 1; i < STAGES; i++) begin
                if (en[i]) begin
                    valid[i] <= valid[i-1];
                end
            end
        end
    end

    // Payload: only real beats move, so an empty output keeps its last value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ovf <= '0;
            for (int i = 0; i < STAGES; i++) begin
                data[i] <= '0;
                tag[i]  <= '0;
            end
        end else if (!flush) begin
            if (en[0] && in_valid) begin
                data[0] <= result[DATA_W-1:0];
                ovf[0]  <= result[DATA_W];
                tag[0]  <= in_tag;
            end
            for (int i = 1; i < STAGES; i++) begin
                if (en[i] && valid[i-1]) begin
                    data[i] <= data[i-1];
                    ovf[i]  <= ovf[i-1];
                    tag[i]  <= tag[i-1];
                end
            end
        end
    end

endmodule
